rll_key_loader: RTL and testbench

- Sequential key provider for the RLL32 locked netlists. Drives the 32 parallel key inputs (keyIn_0_0..keyIn_0_31) of a locked combinational benchmark.
- The key arrives LSB-first over a 1-bit valid/ready serial link from the tamper-protected key store. The block assembles it, optionally parity-checks it, and commits it once.
- Until a key is committed, the locked circuit sees a fixed decoy word, never a partial key.

---
 rtl/rll_key_pkg.sv | 20 ++
 rtl/rll_key_shreg.sv | 52 +++++
 rtl/rll_key_loader.sv | 142 ++++++++++++++
 tb/tb_rll_key_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
// rtl/rll_key_pkg.sv - shared types, defaults and parity helper for the RLL32 key loader
package rll_key_pkg;

    localparam int KEY_WIDTH_DEF = 32;
    localparam int PARITY_MAX_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        LOCKED,
        ERROR
    } state_e;

    // Callers zero-extend into the fixed-width argument; padding zeros do not change the XOR.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// rtl/rll_key_shreg.sv - indexed-write frame register with bit counter, clear and done flag
module rll_key_shreg #(
    parameter int W  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_en,
    input  logic         wr_bit,
    output logic [W-1:0] data,
    output logic         done
);

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A clear in the same cycle as a write wins, so the write never counts as the last bit.
    assign done = wr_en && !clr && (cnt_q == LAST);
    assign data = data_q;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (wr_en) begin
            for (int i = 0; i < W; i++) begin
                if (cnt_q == CW'(i)) begin
                    data_d[i] = wr_bit;
                end
            end
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// rtl/rll_key_loader.sv - serial key loader driving the RLL32 key inputs
// Optional trailing even-parity bit enabled by RLL_KEY_LOADER_PARITY_EN.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
    parameter int                   ONE_TIME  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 sdi,
    input  logic                 sdi_valid,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err
);

`ifdef RLL_KEY_LOADER_PARITY_EN
    localparam int FRAME_LEN = KEY_WIDTH + 1;
`else
    localparam int FRAME_LEN = KEY_WIDTH;
`endif
    localparam int CW = $clog2(KEY_WIDTH + 1);

    state_e               state_q, state_d;
    logic                 sdi_ready_q, sdi_ready_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 start;
    logic [FRAME_LEN-1:0] frame;
    logic                 frame_done;
    logic                 parity_ok;

    rll_key_shreg #(
        .W  (FRAME_LEN),
        .CW (CW)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .clr    (start),
        .wr_en  (sdi_valid && sdi_ready_q),
        .wr_bit (sdi),
        .data   (frame),
        .done   (frame_done)
    );

`ifdef RLL_KEY_LOADER_PARITY_EN
    assign parity_ok = (even_parity({{(PARITY_MAX_W-KEY_WIDTH){1'b0}}, frame[KEY_WIDTH-1:0]})
                        == frame[KEY_WIDTH]);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        start       = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (load_start) begin
                    start = 1'b1;
                end else if (frame_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (parity_ok) begin
                    state_d     = LOCKED;
                    key_d       = frame[KEY_WIDTH-1:0];
                    key_valid_d = 1'b1;
                end else begin
                    state_d     = ERROR;
                    err_d       = 1'b1;
                    key_d       = DECOY_KEY;
                    key_valid_d = 1'b0;
                end
            end
            LOCKED: begin
                // Reload drops the committed key on the same edge that re-enters SHIFT.
                if (ONE_TIME == 0 && load_start) begin
                    state_d     = SHIFT;
                    start       = 1'b1;
                    key_d       = DECOY_KEY;
                    key_valid_d = 1'b0;
                end
            end
            ERROR: begin
                if (load_start) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                key_d       = DECOY_KEY;
                key_valid_d = 1'b0;
            end
        endcase
        sdi_ready_d = (state_d == SHIFT);
        busy_d      = (state_d == SHIFT) || (state_d == CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sdi_ready_q <= 1'b0;
            key_q       <= DECOY_KEY;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdi_ready_q <= sdi_ready_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign sdi_ready = sdi_ready_q;
    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// tb/tb_rll_key_loader.sv - directed self-checking bench for rll_key_loader
// Parity cases run only when RLL_KEY_LOADER_PARITY_EN is defined.
module tb_rll_key_loader;

`ifdef RLL_KEY_LOADER_PARITY_EN
    localparam int FL = 33;
`else
    localparam int FL = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        sdi;
    logic        sdi_valid;
    logic        sdi_ready;
    logic [31:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    rll_key_loader #(
        .KEY_WIDTH (32),
        .DECOY_KEY (32'h0000_0000),
        .ONE_TIME  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .sdi_ready  (sdi_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] mkframe(input logic [31:0] k, input logic p);
        return {p, k};
    endfunction

    task automatic check_reset(input string tag);
        chk1({tag, "_ready"}, sdi_ready, 1'b0);
        chk32({tag, "_key"}, key_out, 32'h0);
        chk1({tag, "_valid"}, key_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push_bits(input logic [31:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            sdi       = bits[k];
            sdi_valid = 1'b1;
            step();
        end
        sdi_valid = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [32:0] frame, input bit gaps);
        int  i      = 0;
        int  budget = 0;
        bit  xfer;
        bit  leak   = 1'b0;
        bit  idle   = 1'b0;
        while (i < FL && budget < 400) begin
            sdi       = frame[i];
            sdi_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer      = sdi_valid && sdi_ready;
            if (key_valid !== 1'b0 || key_out !== 32'h0) leak = 1'b1;
            if (busy !== 1'b1) idle = 1'b1;
            step();
            budget++;
            if (xfer) i++;
        end
        sdi_valid = 1'b0;
        chk32({tag, "_bits_taken"}, 32'(i), 32'(FL));
        chk1({tag, "_no_early_key"}, leak, 1'b0);
        chk1({tag, "_busy_in_shift"}, idle, 1'b0);
    endtask

    task automatic commit(input string tag, input logic [31:0] key, input logic err_exp);
        chk1({tag, "_check_valid"}, key_valid, 1'b0);
        chk32({tag, "_check_key"}, key_out, 32'h0);
        chk1({tag, "_check_busy"}, busy, 1'b1);
        chk1({tag, "_check_ready"}, sdi_ready, 1'b0);
        step();
        chk1({tag, "_valid"}, key_valid, 1'b1);
        chk32({tag, "_key"}, key_out, key);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, err, err_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ready_seen;
        bit key_moved;

        rst        = 1'b1;
        load_start = 1'b0;
        sdi        = 1'b0;
        sdi_valid  = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset("por");

        sdi       = 1'b1;
        sdi_valid = 1'b1;
        step();
        step();
        chk1("idle_ready", sdi_ready, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        sdi_valid = 1'b0;

        // Gap-free load
        start();
        chk1("start_ready", sdi_ready, 1'b1);
        chk1("start_busy", busy, 1'b1);
        send_frame("nogap", mkframe(32'hA5C3_1E07, 1'b0), 1'b0);
        commit("nogap", 32'hA5C3_1E07, 1'b0);

        // One-time lock ignores a second load
        do_reset();
        start();
        send_frame("dead", mkframe(32'hDEAD_BEEF, 1'b0), 1'b0);
        commit("dead", 32'hDEAD_BEEF, 1'b0);
        start();
        ready_seen = 1'b0;
        key_moved  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sdi       = 1'(32'h1234_5678 >> (k % 32));
            sdi_valid = 1'b1;
            if (sdi_ready !== 1'b0) ready_seen = 1'b1;
            if (key_out !== 32'hDEAD_BEEF) key_moved = 1'b1;
            step();
        end
        sdi_valid = 1'b0;
        chk1("lock_ready_seen", ready_seen, 1'b0);
        chk1("lock_key_moved", key_moved, 1'b0);
        chk32("lock_key", key_out, 32'hDEAD_BEEF);
        chk1("lock_valid", key_valid, 1'b1);

        // Random sdi_valid gaps
        do_reset();
        check_reset("rst2");
        start();
        send_frame("gap", mkframe(32'hA5C3_1E07, 1'b0), 1'b1);
        commit("gap", 32'hA5C3_1E07, 1'b0);

        // Reset in the middle of a frame
        do_reset();
        start();
        push_bits(32'hFFFF_FFFF, 20);
        rst       = 1'b1;
        sdi_valid = 1'b1;
        step();
        rst       = 1'b0;
        sdi_valid = 1'b0;
        check_reset("midrst");
        step();
        chk1("midrst_idle_ready", sdi_ready, 1'b0);
        start();
        send_frame("ones", mkframe(32'hFFFF_FFFF, 1'b0), 1'b0);
        commit("ones", 32'hFFFF_FFFF, 1'b0);

        // Restart mid-frame; the transfer coinciding with load_start is dropped
        do_reset();
        start();
        push_bits(32'hFFFF_FFFF, 10);
        load_start = 1'b1;
        sdi        = 1'b1;
        sdi_valid  = 1'b1;
        step();
        load_start = 1'b0;
        sdi_valid  = 1'b0;
        chk1("restart_ready", sdi_ready, 1'b1);
        send_frame("restart", mkframe(32'h0F0F_0F0F, 1'b0), 1'b0);
        commit("restart", 32'h0F0F_0F0F, 1'b0);

`ifdef RLL_KEY_LOADER_PARITY_EN
        do_reset();
        start();
        send_frame("badpar", mkframe(32'h0000_0001, 1'b0), 1'b0);
        chk1("badpar_check_busy", busy, 1'b1);
        step();
        chk1("badpar_err", err, 1'b1);
        chk1("badpar_valid", key_valid, 1'b0);
        chk32("badpar_key", key_out, 32'h0);
        chk1("badpar_busy", busy, 1'b0);
        chk1("badpar_ready", sdi_ready, 1'b0);
        start();
        chk1("reload_err_held", err, 1'b1);
        send_frame("goodpar", mkframe(32'h0000_0001, 1'b1), 1'b0);
        commit("goodpar", 32'h0000_0001, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
